// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external combinational ALU among NREQ requesters.
// Operands and ALU outputs are registered; each result returns over a per-requester valid/ready pair.
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*XLEN-1:0] req_a,
    input  logic [NREQ*XLEN-1:0] req_b,
    input  logic [NREQ*4-1:0]    req_op,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [XLEN-1:0]      rsp_result,
    output logic                 rsp_zero,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    output logic [3:0]           alu_ctrl,
    input  logic [XLEN-1:0]      alu_result,
    input  logic                 alu_zero
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [GW-1:0] LAST_IDX = GW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t        state;
    logic [GW-1:0] gnt;
    logic [GW-1:0] last_gnt;
    logic [GW-1:0] pick;
    logic          found;

    // Rotating priority: the search starts just after the previous winner.
    always_comb begin
        int idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_gnt) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    // Ready is held low during reset so nothing can be accepted while it is asserted.
    assign req_ready = (rst_n && (state == IDLE) && found) ? (NREQ'(1) << pick) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= '0;
            last_gnt   <= LAST_IDX;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_valid  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        alu_a    <= req_a[pick*XLEN +: XLEN];
                        alu_b    <= req_b[pick*XLEN +: XLEN];
                        alu_ctrl <= req_op[pick*4 +: 4];
                        gnt      <= pick;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_valid  <= NREQ'(1) << gnt;
                    state      <= RESP;
                end
                RESP: begin
                    // Only the granted requester's ready can retire the response.
                    if (rsp_ready[gnt]) begin
                        rsp_valid <= '0;
                        last_gnt  <= gnt;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU sits on the alu_* ports and a
// round-robin reference model predicts grants, response routing, latency and results.
module tb_alu_arbiter;
    localparam int NREQ = 2;
    localparam int XLEN = 32;

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        zero;
        int          due;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*XLEN-1:0] req_a = '0;
    logic [NREQ*XLEN-1:0] req_b = '0;
    logic [NREQ*4-1:0]    req_op = '0;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready = '0;
    logic [XLEN-1:0]      rsp_result;
    logic                 rsp_zero;
    logic [XLEN-1:0]      alu_a;
    logic [XLEN-1:0]      alu_b;
    logic [3:0]           alu_ctrl;
    logic [XLEN-1:0]      alu_result;
    logic                 alu_zero;

    exp_t            sb[$];
    int              checks = 0;
    int              failures = 0;
    int              cycle = 0;
    int              last_model = NREQ - 1;
    logic            busy = 1'b0;
    logic [NREQ-1:0] hs_flag = '0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .req_op(req_op),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_result(rsp_result),
        .rsp_zero(rsp_zero),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_ctrl(alu_ctrl),
        .alu_result(alu_result),
        .alu_zero(alu_zero)
    );

    // Behavioural ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, else 0.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return 32'($signed(a) >>> b[4:0]);
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_a, alu_b, alu_ctrl);
        alu_zero   = (alu_result == 32'd0);
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    // Monitor and reference model, sampled on the falling edge.
    always @(negedge clk) begin : monitor
        logic [NREQ-1:0] exp_ready;
        logic [NREQ-1:0] exp_rv;
        logic [31:0]     r;
        int              win;
        int              j;
        cycle++;
        exp_ready = '0;
        exp_rv    = '0;
        win       = -1;
        if (!rst_n) begin
            check_output("reset_req_ready", 64'(req_ready), 64'd0);
            check_output("reset_rsp_valid", 64'(rsp_valid), 64'd0);
            check_output("reset_rsp_result", 64'(rsp_result), 64'd0);
            check_output("reset_rsp_zero", 64'(rsp_zero), 64'd0);
            check_output("reset_alu_a", 64'(alu_a), 64'd0);
            check_output("reset_alu_b", 64'(alu_b), 64'd0);
            check_output("reset_alu_ctrl", 64'(alu_ctrl), 64'd0);
            sb.delete();
            busy       = 1'b0;
            last_model = NREQ - 1;
            hs_flag    = '0;
        end else begin
            if (!busy) begin
                for (int k = 1; k <= NREQ; k++) begin
                    j = (last_model + k) % NREQ;
                    if (win < 0 && req_valid[j]) win = j;
                end
            end
            if (win >= 0) exp_ready[win] = 1'b1;
            check_output("req_ready", 64'(req_ready), 64'(exp_ready));
            if (sb.size() > 0 && cycle >= sb[0].due) begin
                exp_rv[sb[0].idx] = 1'b1;
                check_output("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
                check_output("rsp_result", 64'(rsp_result), 64'(sb[0].res));
                check_output("rsp_zero", 64'(rsp_zero), 64'(sb[0].zero));
                if (rsp_ready[sb[0].idx]) begin
                    last_model = sb[0].idx;
                    busy       = 1'b0;
                    void'(sb.pop_front());
                end
            end else begin
                check_output("rsp_valid_idle", 64'(rsp_valid), 64'd0);
            end
            hs_flag = exp_ready;
            if (win >= 0) begin
                busy = 1'b1;
                r = alu_fn(req_a[win*XLEN +: XLEN], req_b[win*XLEN +: XLEN], req_op[win*4 +: 4]);
                sb.push_back('{win, r, (r == 32'd0), cycle + 2});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs_flag[i]) req_valid[i] = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input int i, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] op);
        req_a[i*XLEN +: XLEN] = a;
        req_b[i*XLEN +: XLEN] = b;
        req_op[i*4 +: 4]      = op;
        req_valid[i]          = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((req_valid != '0 || sb.size() != 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (req_valid != '0 || sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain_timeout: pending valid=%0b queued=%0d after %0d cycles",
                     req_valid, sb.size(), budget);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 8));
        return $urandom;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = '1;

        // Single SUB from requester 0 straight after reset.
        apply_stimulus(0, 32'd5, 32'd3, 4'b0001);
        drain(20);

        // Both requesters continuously busy: grants must alternate.
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i]) apply_stimulus(i, rand_operand(), rand_operand(), 4'($urandom_range(0, 9)));
            step();
        end
        drain(40);

        // Signed vs unsigned compare on requester 1.
        apply_stimulus(1, 32'hFFFF_FFFF, 32'd1, 4'b1000);
        drain(20);
        apply_stimulus(1, 32'hFFFF_FFFF, 32'd1, 4'b1001);
        drain(20);

        // Back-pressure on requester 0's response while requester 1 waits.
        rsp_ready = 2'b10;
        apply_stimulus(0, 32'd100, 32'd23, 4'b0000);
        apply_stimulus(1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0010);
        repeat (8) step();
        rsp_ready = '1;
        drain(20);

        // Reset while a transaction from requester 1 is executing.
        apply_stimulus(0, 32'd1, 32'd2, 4'b0000);
        drain(20);
        apply_stimulus(1, 32'd9, 32'd4, 4'b0000);
        step();
        #1;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        apply_stimulus(0, 32'd11, 32'd22, 4'b0011);
        apply_stimulus(1, 32'd33, 32'd44, 4'b0100);
        drain(30);

        // Unused op code passes through and yields zero.
        apply_stimulus(0, 32'd7, 32'd7, 4'b1111);
        drain(20);

        // Randomised traffic with random response back-pressure.
        for (int c = 0; c < 400; c++) begin
            step();
            rsp_ready = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    apply_stimulus(i, rand_operand(), rand_operand(), 4'($urandom_range(0, 15)));
        end
        rsp_ready = '1;
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
